// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: shared camera constants and readout FSM encoding
package pixel_readout_pkg;
  localparam int CAM_DATA_W = 8;
  localparam int CAM_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, DRAIN = 2'b11} state_t;
endpackage

// File: rtl/pixel_readout_fifo.sv
// pixel_fifo: first-word fall-through sample buffer with flush; a push into a full buffer only lands alongside a pop
module pixel_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW + 1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push & ~flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: captures row-tagged ADC samples per frame into a FIFO and streams them out with valid/ready
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int DATA_W = CAM_DATA_W,
  parameter int FIFO_DEPTH = CAM_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nre1,
  input  logic              nre2,
  input  logic              adc,
  input  logic              erase,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_row,
  output logic              frame_done,
  output logic              overflow,
  output logic              sample_err,
  output logic [7:0]        frame_cnt
);
  state_t state, state_nxt;
  logic adc_q, erase_q, push_q, seen0, seen1;
  logic [DATA_W:0] push_e, head;
  logic empty, full, strobe, valid_sel, arm, abort, done, pop, accepted;
  assign strobe = adc & ~adc_q;
  assign valid_sel = nre1 ^ nre2;
  assign arm = state == IDLE && erase_q && !erase;
  assign abort = state == ARMED && erase;
  assign done = state == DRAIN && empty && !push_q;
  assign pop = pix_ready & ~empty;
  assign accepted = push_q & (~full | pop);
  assign pix_valid = ~empty;
  assign {pix_row, pix_data} = head;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (abort) state_nxt = IDLE; else if (seen0 && seen1) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // the strobe is registered so the push lands one cycle later; an abort cancels it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      adc_q <= 1'b0;
      erase_q <= 1'b0;
      push_q <= 1'b0;
      push_e <= '0;
      sample_err <= 1'b0;
      seen0 <= 1'b0;
      seen1 <= 1'b0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      adc_q <= adc;
      erase_q <= erase;
      push_q <= strobe & valid_sel & state == ARMED & ~erase;
      push_e <= {nre1, adc_data};
      sample_err <= strobe & ~valid_sel & state == ARMED;
      seen0 <= state == ARMED & ~erase & (seen0 | (accepted & ~push_e[DATA_W]));
      seen1 <= state == ARMED & ~erase & (seen1 | (accepted & push_e[DATA_W]));
      overflow <= ~arm & (overflow | (push_q & full & ~pop & ~abort));
      frame_done <= done;
      frame_cnt <= frame_cnt + 8'(done);
    end
  pixel_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(abort),
    .push(push_q),
    .pop(pix_ready),
    .wdata(push_e),
    .rdata(head),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: directed scenarios plus random frames checked against a queue-based behavioural model
module tb_pixel_readout;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, nre1 = 1, nre2 = 1, adc = 0, erase = 1, pix_ready = 1;
  logic [7:0] adc_data = 0;
  logic pix_valid, pix_row, frame_done, overflow, sample_err;
  logic [7:0] pix_data, frame_cnt;
  int n_checks = 0, n_fail = 0, done_cnt = 0, err_cnt = 0;
  logic [8:0] q[$], obs[$];
  int m_phase;
  bit m_pend, m_s0, m_s1, m_ovf, m_done, m_err, m_pa, m_pe;
  logic [8:0] m_ent;
  logic [7:0] m_cnt, d[5];
  int saved_cnt, saved_done;

  pixel_readout dut (
    .clk(clk), .reset(reset), .nre1(nre1), .nre2(nre2), .adc(adc), .erase(erase),
    .adc_data(adc_data), .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_row(pix_row), .frame_done(frame_done), .overflow(overflow), .sample_err(sample_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = 0; m_pend = 0; m_s0 = 0; m_s1 = 0; m_ovf = 0; m_done = 0; m_err = 0;
    m_pa = 0; m_pe = 0; m_cnt = 0; m_ent = 0;
  endtask

  // frame rules: 0 waits for erase fall, 1 collects samples, 2 drains the queue
  task automatic model_step();
    bit stb, fall, popd, abort, nxt_pend, drain_go, go_idle;
    if (!reset) begin
      model_reset();
      return;
    end
    stb = adc && !m_pa;
    fall = m_pe && !erase;
    popd = q.size() > 0 && pix_ready;
    abort = m_phase == 1 && erase;
    nxt_pend = stb && nre1 != nre2 && m_phase == 1 && !erase;
    m_err = stb && nre1 == nre2 && m_phase == 1;
    go_idle = m_phase == 2 && q.size() == 0 && !m_pend;
    drain_go = m_phase == 1 && m_s0 && m_s1 && !abort;
    m_done = go_idle;
    if (abort) q.delete();
    else begin
      if (popd) void'(q.pop_front());
      if (m_pend) begin
        if (q.size() < DEPTH) begin
          q.push_back(m_ent);
          if (m_ent[8]) m_s1 = 1; else m_s0 = 1;
        end else m_ovf = 1;
      end
    end
    if (m_phase != 1 || abort) begin m_s0 = 0; m_s1 = 0; end
    if (m_phase == 0 && fall) begin m_phase = 1; m_ovf = 0; end
    else if (abort) m_phase = 0;
    else if (drain_go) m_phase = 2;
    else if (go_idle) begin m_phase = 0; m_cnt++; end
    m_pend = nxt_pend;
    m_ent = {nre1, adc_data};
    m_pa = adc;
    m_pe = erase;
  endtask

  task automatic cycle();
    logic [8:0] h;
    if (pix_valid && pix_ready) obs.push_back({pix_row, pix_data});
    @(posedge clk);
    model_step();
    @(negedge clk);
    h = q.size() > 0 ? q[0] : 9'h0;
    check("outs", 32'({pix_valid, pix_row, pix_data, frame_done, overflow, sample_err, frame_cnt}),
          32'({q.size() > 0, h, m_done, m_ovf, m_err, m_cnt}));
    if (frame_done) done_cnt++;
    if (sample_err) err_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic strobe(input logic n1, input logic n2, input logic [7:0] dat);
    nre1 = n1; nre2 = n2; adc_data = dat; adc = 1;
    cycle();
    adc = 0;
    cycle();
  endtask

  task automatic arm();
    erase = 1;
    cycle();
    erase = 0;
    cycle();
  endtask

  initial begin
    logic [2:0] sel;
    #1 reset = 0;
    model_reset();
    #1 check("rst_init", 32'({pix_valid, pix_row, pix_data, frame_done, overflow, sample_err, frame_cnt}), 0);
    run(2);
    reset = 1;
    run(2);

    obs.delete(); done_cnt = 0;
    arm();
    strobe(0, 1, 8'h3C);
    strobe(1, 0, 8'hA5);
    run(6);
    check("nom_n", 32'(obs.size()), 2);
    if (obs.size() == 2) begin
      check("nom_px0", 32'(obs[0]), 32'h03C);
      check("nom_px1", 32'(obs[1]), 32'h1A5);
    end
    check("nom_done", 32'(done_cnt), 1);
    check("nom_cnt", 32'(frame_cnt), 1);

    pix_ready = 0;
    arm();
    for (int i = 0; i < 5; i++) begin
      d[i] = 8'($urandom);
      strobe(0, 1, d[i]);
    end
    check("bp_ovf", 32'(overflow), 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", 32'({pix_valid, pix_data}), 32'({1'b1, d[0]}));
      cycle();
    end
    obs.delete();
    pix_ready = 1;
    run(6);
    check("bp_n", 32'(obs.size()), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++) check("bp_px", 32'(obs[i]), 32'({1'b0, d[i]}));
    erase = 1;
    run(2);

    arm();
    err_cnt = 0; saved_done = done_cnt;
    strobe(0, 0, 8'h55);
    check("inv_err", 32'(err_cnt), 1);
    check("inv_empty", 32'(pix_valid), 0);
    strobe(0, 1, 8'h11);
    strobe(1, 0, 8'h22);
    run(6);
    check("inv_armed", 32'(done_cnt), 32'(saved_done + 1));

    pix_ready = 0;
    saved_cnt = frame_cnt; saved_done = done_cnt;
    arm();
    strobe(0, 1, 8'h77);
    check("abort_pre", 32'(pix_valid), 1);
    erase = 1;
    cycle();
    check("abort_flush", 32'(pix_valid), 0);
    run(3);
    check("abort_cnt", 32'(frame_cnt), 32'(saved_cnt));
    check("abort_done", 32'(done_cnt), 32'(saved_done));

    arm();
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      strobe(0, 1, d[i]);
    end
    d[4] = 8'($urandom);
    nre1 = 0; nre2 = 1; adc_data = d[4]; adc = 1;
    cycle();
    adc = 0; pix_ready = 1;
    obs.delete();
    cycle();
    check("sim_ovf", 32'(overflow), 0);
    check("sim_head", 32'({pix_valid, pix_data}), 32'({1'b1, d[1]}));
    run(6);
    check("sim_n", 32'(obs.size()), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) check("sim_px", 32'(obs[i]), 32'({1'b0, d[i]}));
    strobe(1, 0, 8'h5A);
    run(6);

    pix_ready = 0;
    arm();
    strobe(0, 1, 8'h12);
    strobe(1, 0, 8'h34);
    run(2);
    check("drn_pend", 32'(pix_valid), 1);
    #1 reset = 0;
    model_reset();
    #1 check("rst_drain", 32'({pix_valid, pix_row, pix_data, frame_done, overflow, sample_err, frame_cnt}), 0);
    cycle();
    reset = 1;
    pix_ready = 1;
    obs.delete();
    strobe(0, 1, 8'h9A);
    strobe(1, 0, 8'hBC);
    run(4);
    check("rst_quiet", 32'({pix_valid, obs.size() != 0}), 0);

    repeat (30) begin
      arm();
      repeat ($urandom_range(2, 8)) begin
        pix_ready = 1'($urandom_range(0, 1));
        sel = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) erase = 1;
        case (sel)
          3'd0: strobe(0, 0, 8'($urandom));
          3'd1: strobe(1, 1, 8'($urandom));
          3'd2, 3'd3, 3'd4: strobe(0, 1, 8'($urandom));
          default: strobe(1, 0, 8'($urandom));
        endcase
        repeat ($urandom_range(0, 2)) begin
          pix_ready = 1'($urandom_range(0, 1));
          cycle();
        end
      end
      pix_ready = 1;
      run(12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
